// File: rtl/ahb_master.sv
// AHB-Lite master: turns one CPU command (instruction word, control byte, beat count)
// into a SINGLE / INCR / INCRx / WRAPx transfer with wait-state and ERROR handling.
module ahb_master (
  input  logic        HCLK,
  input  logic        HRESETn,
  output logic [31:0] HADDR,
  output logic [2:0]  HBURST,
  output logic [2:0]  HSIZE,
  output logic [1:0]  HTRANS,
  output logic [31:0] HWDATA,
  output logic        HWRITE,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  input  logic [63:0] cpu_inst,
  input  logic [7:0]  cpu_cont,
  input  logic [7:0]  num_beats
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_NONSEQ = 2'b10,
    ST_SEQ    = 2'b11
  } state_t;

  state_t      r_state;
  logic [31:0] r_wdata;
  logic [7:0]  r_len;
  logic [7:0]  r_cnt;
  logic        r_dphase;
  logic        r_dwrite;
  logic [31:0] r_rdata;

  function automatic logic [7:0] burst_len(input logic [2:0] burst, input logic [7:0] beats);
    logic [7:0] len;
    case (burst)
      3'b000:         len = 8'd1;
      3'b001:         len = (beats == 8'd0) ? 8'd1 : beats;
      3'b010, 3'b011: len = 8'd4;
      3'b100, 3'b101: len = 8'd8;
      3'b110, 3'b111: len = 8'd16;
      default:        len = 8'd1;
    endcase
    return len;
  endfunction

  // WRAP bursts keep the upper address bits and let only the in-block offset roll over
  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [2:0] burst,
                                            input logic [2:0] size, input logic [7:0] len);
    logic [31:0] incr;
    logic [31:0] mask;
    incr = 32'd1 << size;
    mask = ({24'd0, len} << size) - 32'd1;
    if ((burst != 3'b000) && !burst[0]) begin
      return (addr & ~mask) | ((addr + incr) & mask);
    end else begin
      return addr + incr;
    end
  endfunction

  assign HTRANS = r_state;

  // Burst sequencer, address/data phase tracking and registered bus outputs
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state  <= ST_IDLE;
      HADDR    <= 32'd0;
      HBURST   <= 3'd0;
      HSIZE    <= 3'd0;
      HWRITE   <= 1'b0;
      HWDATA   <= 32'd0;
      r_wdata  <= 32'd0;
      r_len    <= 8'd0;
      r_cnt    <= 8'd0;
      r_dphase <= 1'b0;
      r_dwrite <= 1'b0;
      r_rdata  <= 32'd0;
    end else if (r_dphase && HRESP) begin
      r_state  <= ST_IDLE;
      r_dphase <= 1'b0;
      r_cnt    <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_dphase && HREADY) begin
            r_dphase <= 1'b0;
            if (!r_dwrite) begin
              r_rdata <= HRDATA;
            end
          end
          // a pending data phase must complete before a new address phase is issued
          if (cpu_cont[7] && (HREADY || !r_dphase)) begin
            r_state <= ST_NONSEQ;
            HADDR   <= cpu_inst[31:0];
            r_wdata <= cpu_inst[63:32];
            HBURST  <= cpu_cont[6:4];
            HSIZE   <= cpu_cont[3:1];
            HWRITE  <= cpu_cont[0];
            r_len   <= burst_len(cpu_cont[6:4], num_beats);
            r_cnt   <= burst_len(cpu_cont[6:4], num_beats) - 8'd1;
          end
        end
        ST_NONSEQ, ST_SEQ: begin
          if (HREADY) begin
            if (r_dphase && !r_dwrite) begin
              r_rdata <= HRDATA;
            end
            r_dphase <= 1'b1;
            r_dwrite <= HWRITE;
            if (HWRITE) begin
              HWDATA <= r_wdata;
            end
            if (r_cnt == 8'd0) begin
              r_state <= ST_IDLE;
            end else begin
              r_cnt   <= r_cnt - 8'd1;
              r_state <= ST_SEQ;
              HADDR   <= next_addr(HADDR, HBURST, HSIZE, r_len);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_master.sv
// Self-checking bench for ahb_master: directed bursts plus randomized bursts against
// an arithmetic model of expected addresses, data phases and read capture.
module tb_ahb_master;
  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [31:0] HADDR;
  logic [2:0]  HBURST;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic [31:0] HWDATA;
  logic        HWRITE;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;
  logic [63:0] cpu_inst;
  logic [7:0]  cpu_cont;
  logic [7:0]  num_beats;

  int          n_checks = 0;
  int          n_err    = 0;
  logic [31:0] exp_rdata;

  ahb_master dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HBURST(HBURST), .HSIZE(HSIZE),
    .HTRANS(HTRANS), .HWDATA(HWDATA), .HWRITE(HWRITE), .HRDATA(HRDATA), .HREADY(HREADY),
    .HRESP(HRESP), .cpu_inst(cpu_inst), .cpu_cont(cpu_cont), .num_beats(num_beats)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  // Issue one command and follow it to completion, checking every cycle
  task automatic run_burst(input logic [31:0] addr, input logic [31:0] wd, input logic [7:0] cont,
                           input logic [7:0] nb, input int stall0, input bit rnd, input int err_beat);
    logic [2:0]  bt;
    logic [2:0]  sz;
    bit          wr;
    int          len;
    int          bytes;
    int          block;
    logic [31:0] base;
    logic [31:0] exp_a[$];
    int          i;
    int          cyc;
    int          stall;
    int          dph_beat;
    bit          dph;
    bit          dph_wr;
    bit          aborted;
    bit          rdy;
    bit          resp;
    bt = cont[6:4];
    sz = cont[3:1];
    wr = cont[0];
    if (bt == 3'd0) len = 1;
    else if (bt == 3'd1) len = (nb == 8'd0) ? 1 : int'(nb);
    else len = 4 << ((int'(bt) - 2) / 2);
    bytes = 1 << sz;
    block = len * bytes;
    base  = addr - (addr % 32'(block));
    for (int k = 0; k < len; k++) begin
      if (bt inside {3'd2, 3'd4, 3'd6})
        exp_a.push_back(base + ((addr - base + 32'(k * bytes)) % 32'(block)));
      else
        exp_a.push_back(addr + 32'(k * bytes));
    end
    cpu_inst  = {wd, addr};
    cpu_cont  = cont;
    num_beats = nb;
    HREADY    = 1'b1;
    HRESP     = 1'b0;
    tick();
    cpu_cont  = {1'b0, 7'($urandom)};
    cpu_inst  = {$urandom, $urandom};
    num_beats = 8'($urandom);
    i = 0; cyc = 0; stall = stall0; dph = 1'b0; dph_wr = 1'b0; dph_beat = 0; aborted = 1'b0;
    while (1) begin
      if (cyc > 300) begin
        chk("timeout", 32'(cyc), 32'd300);
        break;
      end
      if (i < len && !aborted) begin
        chk("htrans", 32'(HTRANS), (i == 0) ? 32'd2 : 32'd3);
        chk("haddr", HADDR, exp_a[i]);
        chk("hburst", 32'(HBURST), 32'(bt));
        chk("hsize", 32'(HSIZE), 32'(sz));
        chk("hwrite", 32'(HWRITE), 32'(wr));
      end else begin
        chk("htrans_idle", 32'(HTRANS), 32'd0);
      end
      if (dph && dph_wr) chk("hwdata", HWDATA, wd);
      if (!dph && (i >= len || aborted)) break;
      if (stall > 0) begin
        rdy = 1'b0;
        stall--;
      end else begin
        rdy = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      resp   = dph && (dph_beat == err_beat);
      HREADY = rdy;
      HRESP  = resp;
      HRDATA = rnd ? $urandom : 32'hDEADBEEF;
      if (resp) begin
        aborted = 1'b1;
        dph     = 1'b0;
      end else if (rdy) begin
        if (dph && !dph_wr) exp_rdata = HRDATA;
        if (i < len) begin
          dph      = 1'b1;
          dph_wr   = wr;
          dph_beat = i;
          i++;
        end else begin
          dph = 1'b0;
        end
      end
      tick();
      cyc++;
    end
    HREADY = 1'b1;
    HRESP  = 1'b0;
    if (!wr) chk("rdata", dut.r_rdata, exp_rdata);
  endtask

  initial begin
    logic [7:0]  rc;
    logic [31:0] ra;
    HRESETn   = 1'b0;
    HRDATA    = 32'd0;
    HREADY    = 1'b1;
    HRESP     = 1'b0;
    cpu_inst  = 64'h000DD000_AAAAAAAA;
    cpu_cont  = 8'b10010011;
    num_beats = 8'd4;
    exp_rdata = 32'd0;
    tick();
    tick();
    chk("rst_htrans", 32'(HTRANS), 32'd0);
    chk("rst_haddr", HADDR, 32'd0);
    chk("rst_hburst", 32'(HBURST), 32'd0);
    chk("rst_hsize", 32'(HSIZE), 32'd0);
    chk("rst_hwrite", 32'(HWRITE), 32'd0);
    chk("rst_hwdata", HWDATA, 32'd0);
    chk("rst_rdata", dut.r_rdata, 32'd0);
    HRESETn = 1'b1;

    // INCR write of 4 halfwords with a 3-cycle initial stall
    run_burst(32'hAAAAAAAA, 32'h000DD000, 8'b10010011, 8'd4, 3, 1'b0, -1);
    // SINGLE read, num_beats ignored
    run_burst(32'hBBBBBBBB, 32'hBBBBBBBB, 8'b10000010, 8'd5, 0, 1'b0, -1);
    chk("single_rdata", dut.r_rdata, 32'hDEADBEEF);
    // WRAP4 word burst starting at the top of its 16-byte block
    run_burst(32'h0000003C, 32'h12345678, 8'b10100101, 8'd0, 0, 1'b0, -1);
    // INCR4 write aborted by ERROR on the data phase of beat 2
    run_burst(32'h00000100, 32'hCAFEF00D, 8'b10110101, 8'd0, 0, 1'b0, 1);
    // INCR with num_beats=0 behaves as one beat
    run_burst(32'h00000200, 32'h0BADF00D, 8'b10010101, 8'd0, 0, 1'b0, -1);

    // Work bit held high: one IDLE cycle, then a new transfer
    cpu_inst = {32'h55AA55AA, 32'h00000400};
    cpu_cont = 8'b10000011;
    HREADY   = 1'b1;
    tick();
    chk("b2b_first", 32'(HTRANS), 32'd2);
    tick();
    chk("b2b_idle", 32'(HTRANS), 32'd0);
    tick();
    chk("b2b_second", 32'(HTRANS), 32'd2);
    chk("b2b_addr", HADDR, 32'h00000400);
    cpu_cont = 8'b00000000;
    tick();
    chk("b2b_wdata", HWDATA, 32'h55AA55AA);
    tick();

    // Randomized bursts with random wait states and mid-burst command noise
    for (int n = 0; n < 24; n++) begin
      rc = 8'($urandom);
      rc[7] = 1'b1;
      rc[3:1] = 3'($urandom_range(0, 2));
      ra = $urandom & ~((32'd1 << rc[3:1]) - 32'd1);
      run_burst(ra, $urandom, rc, 8'($urandom_range(0, 12)), 0, 1'b1, -1);
    end

    // Asynchronous reset in the middle of an INCR4 burst
    cpu_inst  = {32'h11111111, 32'h00001000};
    cpu_cont  = 8'b10110101;
    num_beats = 8'd0;
    HREADY    = 1'b1;
    tick();
    cpu_cont = 8'd0;
    tick();
    tick();
    chk("mid_htrans", 32'(HTRANS), 32'd3);
    chk("mid_haddr", HADDR, 32'h00001008);
    HRESETn = 1'b0;
    #1;
    chk("arst_htrans", 32'(HTRANS), 32'd0);
    chk("arst_haddr", HADDR, 32'd0);
    chk("arst_hburst", 32'(HBURST), 32'd0);
    chk("arst_hwdata", HWDATA, 32'd0);
    tick();
    HRESETn = 1'b1;
    tick();
    chk("post_rst_idle", 32'(HTRANS), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
